// File: rtl/multiword_add_sequencer_pkg.sv
// Shared constants and FSM encoding for the nibble-serial multiword adder.
package multiword_add_sequencer_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        IDLE = ST_IDLE,
        RUN  = ST_RUN
    } state_t;

endpackage

// File: rtl/multiword_add_sequencer_adder.sv
// 4-bit ripple-carry adder: a chain of full adders, carry rippling LSB to MSB.
module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Captures two wide operands and sums them one nibble per clock through a single
// 4-bit adder, chaining the carry through a flop. Optional two's-complement subtract.
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [4*WORDS-1:0]    op_a,
    input  logic [4*WORDS-1:0]    op_b,
    output logic                  busy,
    output logic                  done,
    output logic [4*WORDS-1:0]    sum,
    output logic                  cout,
    output logic                  ovf
);

    localparam int W  = NIBBLE_W * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t           state;
    logic [W-1:0]     a_sh, b_sh, s_sh;
    logic [W-1:0]     b_eff, s_next;
    logic             carry, msb_a, msb_b;
    logic [IW-1:0]    idx;
    logic [NIBBLE_W-1:0] add_sum;
    logic             add_cout;

    // Subtract is A + ~B + 1, so only B is inverted and the carry-in forced high.
    assign b_eff = sub ? ~op_b : op_b;

    ripple_carry_adder u_adder (
        .a    (a_sh[idx*NIBBLE_W +: NIBBLE_W]),
        .b    (b_sh[idx*NIBBLE_W +: NIBBLE_W]),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        s_next = s_sh;
        s_next[idx*NIBBLE_W +: NIBBLE_W] = add_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            msb_a <= 1'b0;
            msb_b <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= op_a;
                        b_sh  <= b_eff;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        msb_a <= op_a[W-1];
                        msb_b <= b_eff[W-1];
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s_sh  <= s_next;
                    carry <= add_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        sum   <= s_next;
                        cout  <= add_cout;
                        // Overflow only when both effective operands share a sign the result lacks.
                        ovf   <= (msb_a == msb_b) && (s_next[W-1] != msb_a);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
